vmem_access_arbiter: RTL and testbench
======================================

Name: vmem_access_arbiter

Overview:
- Single-port arbiter in front of video memory (0x8000-0x9FFF, 8 KB).
- Shares VMEM between three requesters: GPU tile/map fetch, OAM/VRAM DMA engine, and CPU via MMU.
- Fixed priority GPU > DMA > CPU, with a CPU anti-starvation override.
- Pipelined: at most one grant per cycle; read data is returned one cycle after the grant.

Parameters:
- ADDR_W, 13, VMEM word address width (offset from 0x8000).
- DATA_W, 8, data width.
- STARVE_LIMIT, 4, consecutive cycles a CPU request may lose before it is forced to win.

Ports:
- iClock  in  1  system clock
- iReset  in  1  synchronous, active-high reset
- iGpuReq  in  1  GPU read request, level, held until ack
- iGpuAddr  in  ADDR_W  GPU read address
- oGpuAck  out  1  GPU grant pulse
- oGpuRdValid  out  1  GPU read data valid, one cycle after oGpuAck
- iDmaReq  in  1  DMA write request
- iDmaAddr  in  ADDR_W  DMA write address
- iDmaData  in  DATA_W  DMA write data
- oDmaAck  out  1  DMA grant pulse
- iCpuReq  in  1  CPU request
- iCpuWe  in  1  CPU write enable (1 = write)
- iCpuAddr  in  ADDR_W  CPU address
- iCpuData  in  DATA_W  CPU write data
- oCpuAck  out  1  CPU grant pulse
- oCpuRdValid  out  1  CPU read data valid
- oRdData  out  DATA_W  registered read data, shared by GPU and CPU
- iGpuMode  in  2  GPU STAT mode, used only by the optional feature
- oMemAddr  out  ADDR_W  VMEM address
- oMemWe  out  1  VMEM write enable
- oMemData  out  DATA_W  VMEM write data
- iMemData  in  DATA_W  VMEM read data, valid the cycle after oMemAddr is presented

Behaviour:
- Reset: all ack/valid outputs 0; oMemWe 0; oMemAddr, oMemData, oRdData 0; starvation counter 0; pipeline stage cleared.
- Reset asserted mid-transfer: the pending read valid is dropped and no pulse is emitted.
- Requester rules:
  - Hold req, addr, data and we stable until the ack is seen.
  - Ack is a 1-cycle pulse in the cycle the request is sampled.
  - Req may be re-asserted or kept high for back-to-back access; a new ack can come the very next cycle.
- Arbitration (combinational on the sampled requests; one winner per cycle):
  - Priority GPU > DMA > CPU.
  - Override: if the starvation counter == STARVE_LIMIT and iCpuReq = 1, the CPU wins over GPU and DMA.
- Starvation counter:
  - Increments on each cycle iCpuReq = 1 without oCpuAck.
  - Saturates at STARVE_LIMIT.
  - Clears on oCpuAck or when iCpuReq = 0.
- Grant cycle N: oMemAddr, oMemWe and oMemData are driven combinationally from the winner.
  - oMemWe = 1 for a DMA grant, or a CPU grant with iCpuWe = 1.
  - With no winner: oMemWe = 0, and oMemAddr holds its last value.
- Cycle N+1, read grants only: oRdData <= iMemData, and exactly one of oGpuRdValid / oCpuRdValid pulses.
  - The ownership tag is registered at cycle N.
  - Write grants produce no valid pulse.
- Back-to-back:
  - GPU read at N and CPU read at N+1 give oGpuRdValid at N+1 and oCpuRdValid at N+2.
  - oRdData changes each cycle accordingly.
- Simultaneous all-three requests with counter < limit: GPU at N; DMA at N+1 if GPU drops req, otherwise GPU repeats; CPU is served by N+STARVE_LIMIT at latest.
- Address wrap: none. Addresses are ADDR_W wide and the arbiter does no range check.

Optional Feature:
- Macro: VMEM_ARB_MODE3_LOCKOUT_EN.
- Defined:
  - While iGpuMode == 2'd3 (pixel transfer), CPU grants still ack but never touch memory.
  - CPU writes are discarded: oMemWe stays 0.
  - CPU reads return oRdData = 0xFF with oCpuRdValid one cycle later.
  - The starvation override is inhibited in mode 3.
- Undefined: iGpuMode is ignored and CPU accesses proceed normally.

Test Plan:
- Reset held 3 cycles with all requests high -> no ack or valid pulses, oMemWe = 0; first ack (GPU) in the first cycle after reset deasserts.
- GPU read 0x1800 with iMemData = 0x3C next cycle -> oGpuAck at N, oGpuRdValid = 1 and oRdData = 0x3C at N+1; no CPU valid.
- DMA write 0x0010 = 0xA5 alongside a CPU read 0x0010 -> DMA ack at N with oMemWe = 1, CPU ack at N+1, CPU read returns 0xA5 at N+2.
- GPU requesting continuously, CPU read pending, STARVE_LIMIT = 4 -> oCpuAck exactly 4 cycles after CPU req rises; GPU resumes the next cycle.
- Reset pulsed the cycle after a CPU read ack -> oCpuRdValid never pulses.
- With VMEM_ARB_MODE3_LOCKOUT_EN, iGpuMode = 3:
  - CPU write 0x0000 = 0x55 -> ack, oMemWe = 0.
  - CPU read -> oRdData = 0xFF.
  - With iGpuMode = 0, the same read returns the memory contents.

Source files
------------

// File: rtl/vmem_access_arbiter.sv
// Single-port VMEM arbiter: GPU > DMA > CPU with a CPU anti-starvation override.
// Build macro VMEM_ARB_MODE3_LOCKOUT_EN blocks CPU memory traffic while iGpuMode == 3.
module vmem_access_arbiter #(
   parameter int ADDR_W       = 13,
   parameter int DATA_W       = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              iClock,
   input  logic              iReset,
   input  logic              iGpuReq,
   input  logic [ADDR_W-1:0] iGpuAddr,
   output logic              oGpuAck,
   output logic              oGpuRdValid,
   input  logic              iDmaReq,
   input  logic [ADDR_W-1:0] iDmaAddr,
   input  logic [DATA_W-1:0] iDmaData,
   output logic              oDmaAck,
   input  logic              iCpuReq,
   input  logic              iCpuWe,
   input  logic [ADDR_W-1:0] iCpuAddr,
   input  logic [DATA_W-1:0] iCpuData,
   output logic              oCpuAck,
   output logic              oCpuRdValid,
   output logic [DATA_W-1:0] oRdData,
   input  logic [1:0]        iGpuMode,
   output logic [ADDR_W-1:0] oMemAddr,
   output logic              oMemWe,
   output logic [DATA_W-1:0] oMemData,
   input  logic [DATA_W-1:0] iMemData
);
   localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0]  r_starve;
   logic [ADDR_W-1:0] r_lastAddr;
   logic [DATA_W-1:0] r_rdHold;
   logic              r_gpuVld_p1;
   logic              r_cpuVld_p1;
   logic              r_cpuBlank_p1;

   logic              w_cpuLock;
   logic              w_override;
   logic              w_gpuWin;
   logic              w_dmaWin;
   logic              w_cpuWin;
   logic [DATA_W-1:0] w_rdOut;

`ifdef VMEM_ARB_MODE3_LOCKOUT_EN
   assign w_cpuLock = (iGpuMode == 2'd3);
`else
   // Mode input is kept on the port list but has no effect in this build.
   assign w_cpuLock = 1'b0 & (iGpuMode == 2'd3);
`endif

   assign w_override = iCpuReq & ~w_cpuLock & (r_starve == STARVE_MAX);

   always_comb begin
      w_gpuWin = 1'b0;
      w_dmaWin = 1'b0;
      w_cpuWin = 1'b0;
      if (!iReset) begin
         if (w_override)   w_cpuWin = 1'b1;
         else if (iGpuReq) w_gpuWin = 1'b1;
         else if (iDmaReq) w_dmaWin = 1'b1;
         else if (iCpuReq) w_cpuWin = 1'b1;
      end
   end

   // Grant stage: memory port follows the winner; address holds when idle or locked out.
   always_comb begin
      oMemAddr = r_lastAddr;
      oMemWe   = 1'b0;
      oMemData = '0;
      if (w_gpuWin) begin
         oMemAddr = iGpuAddr;
      end else if (w_dmaWin) begin
         oMemAddr = iDmaAddr;
         oMemWe   = 1'b1;
         oMemData = iDmaData;
      end else if (w_cpuWin && !w_cpuLock) begin
         oMemAddr = iCpuAddr;
         oMemWe   = iCpuWe;
         oMemData = iCpuData;
      end
   end

   assign oGpuAck = w_gpuWin;
   assign oDmaAck = w_dmaWin;
   assign oCpuAck = w_cpuWin;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_starve      <= '0;
         r_lastAddr    <= '0;
         r_rdHold      <= '0;
         r_gpuVld_p1   <= 1'b0;
         r_cpuVld_p1   <= 1'b0;
         r_cpuBlank_p1 <= 1'b0;
      end else begin
         r_lastAddr    <= oMemAddr;
         r_gpuVld_p1   <= w_gpuWin;
         r_cpuVld_p1   <= w_cpuWin & ~iCpuWe;
         r_cpuBlank_p1 <= w_cpuWin & w_cpuLock;
         if (r_gpuVld_p1 | r_cpuVld_p1) r_rdHold <= w_rdOut;
         if (!iCpuReq || w_cpuWin)
            r_starve <= '0;
         else if (r_starve != STARVE_MAX)
            r_starve <= r_starve + 1'b1;
      end
   end

   // Return stage: a reset in this cycle swallows the pending valid.
   assign w_rdOut     = r_cpuBlank_p1 ? {DATA_W{1'b1}} : iMemData;
   assign oGpuRdValid = r_gpuVld_p1 & ~iReset;
   assign oCpuRdValid = r_cpuVld_p1 & ~iReset;
   assign oRdData     = (oGpuRdValid | oCpuRdValid) ? w_rdOut : r_rdHold;

endmodule

// File: tb/tb_vmem_access_arbiter.sv
// Bench for vmem_access_arbiter: vector table, directed corner sequences, random traffic vs. a reference model.
module tb_vmem_access_arbiter;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;
   localparam int LIM    = 4;

   logic              iClock = 1'b0;
   logic              iReset = 1'b1;
   logic              iGpuReq = 1'b0;
   logic [ADDR_W-1:0] iGpuAddr = '0;
   logic              oGpuAck, oGpuRdValid;
   logic              iDmaReq = 1'b0;
   logic [ADDR_W-1:0] iDmaAddr = '0;
   logic [DATA_W-1:0] iDmaData = '0;
   logic              oDmaAck;
   logic              iCpuReq = 1'b0;
   logic              iCpuWe = 1'b0;
   logic [ADDR_W-1:0] iCpuAddr = '0;
   logic [DATA_W-1:0] iCpuData = '0;
   logic              oCpuAck, oCpuRdValid;
   logic [DATA_W-1:0] oRdData;
   logic [1:0]        iGpuMode = 2'd0;
   logic [ADDR_W-1:0] oMemAddr;
   logic              oMemWe;
   logic [DATA_W-1:0] oMemData;
   logic [DATA_W-1:0] iMemData;

   int n_checks = 0;
   int n_err    = 0;

   always #5 iClock = ~iClock;

   vmem_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIM)) dut (
      .iClock(iClock), .iReset(iReset),
      .iGpuReq(iGpuReq), .iGpuAddr(iGpuAddr), .oGpuAck(oGpuAck), .oGpuRdValid(oGpuRdValid),
      .iDmaReq(iDmaReq), .iDmaAddr(iDmaAddr), .iDmaData(iDmaData), .oDmaAck(oDmaAck),
      .iCpuReq(iCpuReq), .iCpuWe(iCpuWe), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
      .oCpuAck(oCpuAck), .oCpuRdValid(oCpuRdValid), .oRdData(oRdData), .iGpuMode(iGpuMode),
      .oMemAddr(oMemAddr), .oMemWe(oMemWe), .oMemData(oMemData), .iMemData(iMemData)
   );

   function automatic logic [7:0] init_val(input int a);
      if (a == 'h1800) return 8'h3C;
      return 8'((a * 37 + 11) & 255);
   endfunction

   // Synchronous VMEM: data for the address presented in cycle N appears in cycle N+1.
   logic [7:0] ram [0:8191];
   logic       ram_ready = 1'b0;
   always @(posedge iClock) begin
      if (!ram_ready) begin
         for (int i = 0; i < 8192; i++) ram[i] <= init_val(i);
         ram_ready <= 1'b1;
      end else if (oMemWe) begin
         ram[oMemAddr] <= oMemData;
      end
      iMemData <= ram[oMemAddr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who wins, what memory holds, which read comes back next cycle.
   logic [7:0]  refmem [0:8191];
   int          m_wait = 0;
   int          m_pend = 0;
   logic [7:0]  m_pdata = '0;
   logic [7:0]  m_last_rd = '0;
   logic [12:0] m_last_addr = '0;

   initial for (int i = 0; i < 8192; i++) refmem[i] = init_val(i);

   task automatic model_cycle();
      int          win;
      logic        lock;
      logic        ewe;
      logic [12:0] ea;
      logic [7:0]  erd;
`ifdef VMEM_ARB_MODE3_LOCKOUT_EN
      lock = (iGpuMode == 2'd3);
`else
      lock = 1'b0;
`endif
      win = 0;
      if (!iReset) begin
         if (iCpuReq && !lock && m_wait >= LIM) win = 3;
         else if (iGpuReq) win = 1;
         else if (iDmaReq) win = 2;
         else if (iCpuReq) win = 3;
      end
      ewe = (win == 2) || (win == 3 && iCpuWe && !lock);
      ea  = (win == 1) ? iGpuAddr : (win == 2) ? iDmaAddr :
            (win == 3 && !lock) ? iCpuAddr : m_last_addr;
      erd = (m_pend != 0) ? m_pdata : m_last_rd;
      chk("m_gpu_ack", 32'(oGpuAck), 32'(win == 1));
      chk("m_dma_ack", 32'(oDmaAck), 32'(win == 2));
      chk("m_cpu_ack", 32'(oCpuAck), 32'(win == 3));
      chk("m_mem_we", 32'(oMemWe), 32'(ewe));
      chk("m_gpu_vld", 32'(oGpuRdValid), 32'(!iReset && m_pend == 1));
      chk("m_cpu_vld", 32'(oCpuRdValid), 32'(!iReset && m_pend == 2));
      if (!iReset) begin
         chk("m_mem_addr", 32'(oMemAddr), 32'(ea));
         chk("m_rd_data", 32'(oRdData), 32'(erd));
         if (ewe) chk("m_mem_data", 32'(oMemData), 32'((win == 2) ? iDmaData : iCpuData));
      end
      if (iReset) begin
         m_wait = 0; m_pend = 0; m_last_addr = '0; m_last_rd = '0;
      end else begin
         if (m_pend != 0) m_last_rd = m_pdata;
         m_pend = 0;
         case (win)
            1: begin m_pend = 1; m_pdata = refmem[iGpuAddr]; end
            2: refmem[iDmaAddr] = iDmaData;
            3: if (lock) begin
                  if (!iCpuWe) begin m_pend = 2; m_pdata = 8'hFF; end
               end else if (iCpuWe) refmem[iCpuAddr] = iCpuData;
               else begin m_pend = 2; m_pdata = refmem[iCpuAddr]; end
            default: ;
         endcase
         m_last_addr = ea;
         if (iCpuReq && win != 3) m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
         else m_wait = 0;
      end
   endtask

   always @(negedge iClock) model_cycle();

   task automatic tick();
      @(posedge iClock);
      #1;
   endtask

   task automatic idle();
      iGpuReq = 1'b0; iDmaReq = 1'b0; iCpuReq = 1'b0; iCpuWe = 1'b0;
   endtask

   typedef struct {
      logic gpu, dma, cpu, we;
      logic e_gack, e_dack, e_cack, e_mwe;
   } vec_t;
   vec_t vecs [9];

   logic ga, da, ca;

   initial begin
      vecs[0] = '{1,0,0,0, 1,0,0,0};
      vecs[1] = '{0,1,0,0, 0,1,0,1};
      vecs[2] = '{0,0,1,0, 0,0,1,0};
      vecs[3] = '{0,0,1,1, 0,0,1,1};
      vecs[4] = '{1,1,0,0, 1,0,0,0};
      vecs[5] = '{0,1,1,1, 0,1,0,1};
      vecs[6] = '{1,0,1,1, 1,0,0,0};
      vecs[7] = '{1,1,1,0, 1,0,0,0};
      vecs[8] = '{0,0,0,0, 0,0,0,0};

      // Reset held three cycles with every requester active.
      iGpuReq = 1; iDmaReq = 1; iCpuReq = 1; iCpuWe = 1;
      iGpuAddr = 13'h0100; iDmaAddr = 13'h0200; iDmaData = 8'h11; iCpuAddr = 13'h0300; iCpuData = 8'h22;
      repeat (3) begin
         @(negedge iClock);
         chk("rst_acks", 32'({oGpuAck, oDmaAck, oCpuAck}), 32'(0));
         chk("rst_vld", 32'({oGpuRdValid, oCpuRdValid}), 32'(0));
         chk("rst_we", 32'(oMemWe), 32'(0));
      end
      tick(); iReset = 1'b0;
      @(negedge iClock);
      chk("rst_first_gpu_ack", 32'(oGpuAck), 32'(1));
      chk("rst_first_addr", 32'(oMemAddr), 32'h0100);
      tick(); idle();

      // GPU read of 0x1800.
      tick(); iGpuReq = 1; iGpuAddr = 13'h1800;
      @(negedge iClock);
      chk("gpu_ack", 32'(oGpuAck), 32'(1));
      chk("gpu_addr", 32'(oMemAddr), 32'h1800);
      tick(); idle();
      @(negedge iClock);
      chk("gpu_vld", 32'(oGpuRdValid), 32'(1));
      chk("gpu_data", 32'(oRdData), 32'h3C);
      chk("gpu_no_cpu_vld", 32'(oCpuRdValid), 32'(0));

      // DMA write followed by CPU read of the same byte.
      tick(); iDmaReq = 1; iDmaAddr = 13'h0010; iDmaData = 8'hA5;
      iCpuReq = 1; iCpuWe = 0; iCpuAddr = 13'h0010;
      @(negedge iClock);
      chk("dma_ack", 32'(oDmaAck), 32'(1));
      chk("dma_we", 32'(oMemWe), 32'(1));
      chk("dma_cpu_wait", 32'(oCpuAck), 32'(0));
      tick(); iDmaReq = 0;
      @(negedge iClock);
      chk("cpu_after_dma_ack", 32'(oCpuAck), 32'(1));
      tick(); idle();
      @(negedge iClock);
      chk("cpu_rd_vld", 32'(oCpuRdValid), 32'(1));
      chk("cpu_rd_data", 32'(oRdData), 32'hA5);

      // Starvation override with the GPU requesting continuously.
      tick(); iGpuReq = 1; iGpuAddr = 13'h0040; iCpuReq = 1; iCpuWe = 0; iCpuAddr = 13'h0041;
      for (int k = 0; k < LIM; k++) begin
         @(negedge iClock);
         chk("starve_gpu_wins", 32'(oGpuAck), 32'(1));
         chk("starve_cpu_waits", 32'(oCpuAck), 32'(0));
         tick();
      end
      @(negedge iClock);
      chk("starve_cpu_forced", 32'(oCpuAck), 32'(1));
      chk("starve_gpu_held", 32'(oGpuAck), 32'(0));
      tick(); iCpuReq = 0;
      @(negedge iClock);
      chk("starve_gpu_resumes", 32'(oGpuAck), 32'(1));
      tick(); idle();

      // Reset in the cycle after a CPU read grant.
      tick(); iCpuReq = 1; iCpuWe = 0; iCpuAddr = 13'h0005;
      @(negedge iClock);
      chk("rstmid_cpu_ack", 32'(oCpuAck), 32'(1));
      tick(); idle(); iReset = 1;
      @(negedge iClock);
      chk("rstmid_no_vld", 32'(oCpuRdValid), 32'(0));
      tick(); iReset = 0;
      @(negedge iClock);
      chk("rstmid_no_vld_after", 32'(oCpuRdValid), 32'(0));

      // Arbitration vector table; an idle cycle between entries clears the starvation count.
      for (int i = 0; i < 9; i++) begin
         tick();
         iGpuReq = vecs[i].gpu; iDmaReq = vecs[i].dma; iCpuReq = vecs[i].cpu; iCpuWe = vecs[i].we;
         iGpuAddr = 13'(i); iDmaAddr = 13'(i + 16); iCpuAddr = 13'(i + 32); iDmaData = 8'(i); iCpuData = 8'(i + 64);
         @(negedge iClock);
         chk($sformatf("vec%0d_gack", i), 32'(oGpuAck), 32'(vecs[i].e_gack));
         chk($sformatf("vec%0d_dack", i), 32'(oDmaAck), 32'(vecs[i].e_dack));
         chk($sformatf("vec%0d_cack", i), 32'(oCpuAck), 32'(vecs[i].e_cack));
         chk($sformatf("vec%0d_we", i), 32'(oMemWe), 32'(vecs[i].e_mwe));
         tick(); idle();
      end

`ifdef VMEM_ARB_MODE3_LOCKOUT_EN
      // Mode 3 lockout: CPU write dropped, CPU read returns 0xFF.
      tick(); iGpuMode = 2'd3; iCpuReq = 1; iCpuWe = 1; iCpuAddr = 13'h0000; iCpuData = 8'h55;
      @(negedge iClock);
      chk("lock_wr_ack", 32'(oCpuAck), 32'(1));
      chk("lock_wr_we", 32'(oMemWe), 32'(0));
      tick(); iCpuWe = 0;
      @(negedge iClock);
      chk("lock_rd_ack", 32'(oCpuAck), 32'(1));
      tick(); idle();
      @(negedge iClock);
      chk("lock_rd_vld", 32'(oCpuRdValid), 32'(1));
      chk("lock_rd_ff", 32'(oRdData), 32'hFF);
      tick(); iGpuMode = 2'd0; iCpuReq = 1; iCpuWe = 0; iCpuAddr = 13'h0000;
      @(negedge iClock);
      chk("mode0_rd_ack", 32'(oCpuAck), 32'(1));
      tick(); idle();
      @(negedge iClock);
      chk("mode0_rd_data", 32'(oRdData), 32'(init_val(0)));
`endif

      // Random traffic; requesters hold their request stable until acked.
      for (int c = 0; c < 3000; c++) begin
         @(negedge iClock);
         ga = oGpuAck; da = oDmaAck; ca = oCpuAck;
         tick();
         iReset = ($urandom_range(0, 199) == 0);
         if (!iGpuReq || ga) begin
            iGpuReq = ($urandom_range(0, 2) != 0);
            iGpuAddr = 13'($urandom_range(0, 31));
         end
         if (!iDmaReq || da) begin
            iDmaReq = ($urandom_range(0, 2) == 0);
            iDmaAddr = 13'($urandom_range(0, 31));
            iDmaData = 8'($urandom);
         end
         if (!iCpuReq || ca) begin
            iCpuReq = ($urandom_range(0, 1) == 0);
            iCpuWe = 1'($urandom_range(0, 1));
            iCpuAddr = 13'($urandom_range(0, 31));
            iCpuData = 8'($urandom);
         end
`ifdef VMEM_ARB_MODE3_LOCKOUT_EN
         iGpuMode = 2'($urandom_range(0, 3));
`endif
      end
      tick(); iReset = 0; idle();
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
